dot_matrix_mark_scanner: RTL and testbench
==========================================

// Module: dot_matrix_mark_scanner
// PURPOSE
//  Holds the 8x16 bomb-field mark map and scans it onto the dot matrix.
//  Keypad index (0-15) plus selected area (0-7) toggles one cell mark.
//  A mark on a bomb cell ends the game, and the display then flashes.
//  Sits downstream of the keypad decoder and area FSM; drives dotR/dotC pins.
// PARAMETERS
//  BOMB_MAP      128'h0000_0000_0000_0000_0000_0000_0000_0001  bit b=1: cell b is a bomb
//  FLASH_CYCLES  5000   clocks per flash half-period (0.5 s at 10 kHz), >=1
// PORTS
//  div_clk_10k  in   1    scan/update clock, 10 kHz
//  reset        in   1    async active-low reset
//  key_tgl      in   1    toggles once per keypad press; from clock domain, held between presses
//  key_index    in   4    cell index within area; stable >=4 cycles around each key_tgl change
//  area         in   3    currently selected area (area FSM state), quasi-static
//  clear        in   1    sync level, active-high: wipe map and game state
//  dot_r        out  8    row drive, active-low one-hot
//  dot_c        out  16   column data for active row, active-high
//  gameover     out  1    sticky: bomb cell marked
//  mark_count   out  8    number of set marks, 0..128
// BEHAVIOUR
//  Reset is async, active-low, on div_clk_10k: map=0, gameover=0, mark_count=0,
//    dot_r=8'hFF, dot_c=16'h0, scan row=0, flash counter=0, flash phase=1, sync flops=0.
//  Cell mapping: grow = 4*(area/4) + key_index/4; gcol = 4*(area%4) + key_index%4;
//    bit = 16*grow + gcol (7-bit, no overflow possible).
//  Key sync: 2-FF synchroniser on key_tgl, then a third flop; key_event = s2 ^ s3.
//    The map update happens on the 3rd rising edge after the key_tgl change.
//    key_index and area are sampled at that edge.
//  On key_event with gameover=0 and clear=0:
//    - if BOMB_MAP[bit]=1: gameover<=1; map and mark_count unchanged.
//    - else: map[bit] toggles; mark_count +1 if set, -1 if cleared.
//      Saturation is never reached (128 cells max).
//  key_event while gameover=1: ignored (no map/count change).
//  clear=1: map<=0, mark_count<=0, gameover<=0, flash counter<=0, phase<=1.
//    Clear wins over a same-cycle key_event; that event is dropped.
//    Scan continues during clear.
//  Scan: row r increments 0..7 every clock and wraps 7->0.
//    dot_r and dot_c are registered, so they update every edge:
//    dot_r <= ~(8'h80 >> r); dot_c <= row slice map[16r+15:16r],
//    post-update map value (new mark visible within 8 cycles).
//  Flash (gameover=1 only): counter counts 0..FLASH_CYCLES-1, wraps, toggles phase.
//    phase=1: dot_c = map slice | BOMB_MAP slice (bombs revealed).
//    phase=0: dot_c = 16'h0.
//    dot_r keeps scanning in both phases. Counter is held at 0, phase=1, while gameover=0.
//  Reset mid-press: a pending toggle is lost; the next key_tgl change after
//    reset is a fresh event.
// STRUCTURE
//  Package bomb_pkg: ROWS=8, COLS=16, AREA_W=3, IDX_W=4, CELLS=128,
//    function cell_bit(area, idx) returning the 7-bit index above (shared with keypad/area logic).
//  Sub-module toggle_sync: 2-FF sync + edge flop, output 1-cycle event pulse.
//  Top holds the map/count/gameover registers, scan counter and flash counter.
// TESTING
//  1. Reset, idle 16 cycles -> dot_r cycles 7F,BF,DF,EF,F7,FB,FD,FE,7F...;
//     dot_c=0; mark_count=0.
//  2. area=5, key_index=6, toggle key_tgl -> on the 3rd edge map bit 16*5+6=86 set;
//     row5 dot_c=16'h0040; mark_count=1.
//  3. Repeat test 2's press -> bit 86 cleared, mark_count=0.
//     Presses on 3 distinct cells -> mark_count=3.
//  4. area=0, key_index=0 (bomb) -> gameover=1, mark_count unchanged.
//     Row0 dot_c alternates 16'h0001 / 16'h0000 every 5000 cycles.
//     Further presses make no change.
//  5. key event and clear=1 on the same edge -> map=0, mark_count=0,
//     gameover=0, and the event is dropped.
//  6. Assert reset mid-scan with marks set -> immediate dot_r=FF, dot_c=0,
//     map cleared; after release the scan restarts at row 0.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared constants and cell addressing for the bomb-field mark map.
// The keypad and area logic use cell_bit too, so the field layout is defined only here.
package bomb_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 16;
  localparam int AREA_W = 3;
  localparam int IDX_W  = 4;
  localparam int CELLS  = 128;

  // Areas tile the 8x16 field as 2 rows by 4 columns of 4x4 blocks.
  // The row is {area[2], idx[3:2]} and the column is {area[1:0], idx[1:0]}.
  function automatic logic [6:0] cell_bit(input logic [AREA_W-1:0] area,
                                          input logic [IDX_W-1:0]  idx);
    logic [2:0] grow;
    logic [3:0] gcol;
    grow = {area[2], idx[3:2]};
    gcol = {area[1:0], idx[1:0]};
    return {grow, gcol};
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Brings the keypad toggle level into div_clk_10k and turns each level change into a
// single-cycle event. The event is s2 ^ s3, so the map updates on the third edge after a change.
module toggle_sync (
  input  logic div_clk_10k,
  input  logic reset,
  input  logic key_tgl,
  output logic key_event
);

  logic s1;
  logic s2;
  logic s3;

  // Two synchroniser stages followed by one edge-detect stage.
  always_ff @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= key_tgl;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign key_event = s2 ^ s3;

endmodule

// File: rtl/dot_matrix_mark_scanner.sv
// Holds the 8x16 mark map, toggles cells from keypad events, tracks gameover,
// and scans the map onto the dot matrix. Once gameover is set, the display flashes with the bombs revealed.
module dot_matrix_mark_scanner
  import bomb_pkg::*;
#(
  parameter logic [127:0] BOMB_MAP     = 128'h0000_0000_0000_0000_0000_0000_0000_0001,
  parameter int           FLASH_CYCLES = 5000
) (
  input  logic        div_clk_10k,
  input  logic        reset,
  input  logic        key_tgl,
  input  logic [3:0]  key_index,
  input  logic [2:0]  area,
  input  logic        clear,
  output logic [7:0]  dot_r,
  output logic [15:0] dot_c,
  output logic        gameover,
  output logic [7:0]  mark_count
);

  localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_CYCLES - 1);

  logic          key_event;
  logic [6:0]    hit;
  logic [127:0]  map;
  logic [127:0]  map_next;
  logic [7:0]    count_next;
  logic          gameover_next;
  logic [2:0]    row;
  logic [FW-1:0] flash_cnt;
  logic [FW-1:0] flash_next;
  logic          phase;
  logic          phase_next;
  logic [15:0]   row_bits;
  logic [15:0]   bomb_bits;
  logic [15:0]   dot_c_next;
  logic [7:0]    dot_r_next;

  toggle_sync u_sync (
    .div_clk_10k (div_clk_10k),
    .reset       (reset),
    .key_tgl     (key_tgl),
    .key_event   (key_event)
  );

  // Map, count and gameover update. A clear drops any key event in the same cycle.
  always_comb begin
    hit           = cell_bit(area, key_index);
    map_next      = map;
    count_next    = mark_count;
    gameover_next = gameover;
    if (clear) begin
      map_next      = 128'h0;
      count_next    = 8'd0;
      gameover_next = 1'b0;
    end else if (key_event && !gameover) begin
      if (BOMB_MAP[hit]) begin
        gameover_next = 1'b1;
      end else begin
        map_next[hit] = ~map[hit];
        if (map[hit]) begin
          count_next = mark_count - 8'd1;
        end else begin
          count_next = mark_count + 8'd1;
        end
      end
    end else begin
      map_next      = map;
      count_next    = mark_count;
      gameover_next = gameover;
    end
  end

  // The flash timer runs only while gameover is set. Otherwise it is parked in the lit phase.
  always_comb begin
    flash_next = flash_cnt;
    phase_next = phase;
    if (clear || !gameover) begin
      flash_next = '0;
      phase_next = 1'b1;
    end else if (flash_cnt == FLASH_LAST) begin
      flash_next = '0;
      phase_next = ~phase;
    end else begin
      flash_next = flash_cnt + 1'b1;
      phase_next = phase;
    end
  end

  // Display data for the current row, built from the updated map so a new mark appears within one scan.
  always_comb begin
    row_bits   = map_next[{row, 4'b0000} +: 16];
    bomb_bits  = BOMB_MAP[{row, 4'b0000} +: 16];
    dot_r_next = ~(8'h80 >> row);
    if (!phase_next) begin
      dot_c_next = 16'h0000;
    end else if (gameover_next) begin
      dot_c_next = row_bits | bomb_bits;
    end else begin
      dot_c_next = row_bits;
    end
  end

  // Game state and flash timer registers.
  always_ff @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      map        <= 128'h0;
      mark_count <= 8'd0;
      gameover   <= 1'b0;
      flash_cnt  <= '0;
      phase      <= 1'b1;
    end else begin
      map        <= map_next;
      mark_count <= count_next;
      gameover   <= gameover_next;
      flash_cnt  <= flash_next;
      phase      <= phase_next;
    end
  end

  // Row scan and registered matrix drive. The scan keeps running during clear.
  always_ff @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      row   <= 3'd0;
      dot_r <= 8'hFF;
      dot_c <= 16'h0000;
    end else begin
      row   <= row + 3'd1;
      dot_r <= dot_r_next;
      dot_c <= dot_c_next;
    end
  end

endmodule

// File: tb/tb_dot_matrix_mark_scanner.sv
// Scoreboard bench: a cell-level reference model predicts every scan output, and a negedge monitor compares against it.
module tb_dot_matrix_mark_scanner;

  localparam logic [127:0] BOMB = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
  localparam int FC = 5000;

  logic        div_clk_10k = 1'b0;
  logic        reset;
  logic        key_tgl;
  logic [3:0]  key_index;
  logic [2:0]  area;
  logic        clear;
  logic [7:0]  dot_r;
  logic [15:0] dot_c;
  logic        gameover;
  logic [7:0]  mark_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  r;
    logic [15:0] c;
    logic        go;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];

  // Reference model state.
  bit [127:0] m_map;
  bit         m_go;
  int         m_gstart;
  int         edge_n;
  int         m_row;
  bit         p1, p2, p3;

  dot_matrix_mark_scanner #(.BOMB_MAP(BOMB), .FLASH_CYCLES(FC)) dut (
    .div_clk_10k (div_clk_10k),
    .reset       (reset),
    .key_tgl     (key_tgl),
    .key_index   (key_index),
    .area        (area),
    .clear       (clear),
    .dot_r       (dot_r),
    .dot_c       (dot_c),
    .gameover    (gameover),
    .mark_count  (mark_count)
  );

  always #5 div_clk_10k = ~div_clk_10k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a key change seen at edge k-3 -> k-2 lands at edge k; outputs reflect post-update state.
  always @(posedge div_clk_10k or negedge reset) begin
    if (!reset) begin
      m_map = '0; m_go = 1'b0; m_gstart = 0; edge_n = 0; m_row = 0;
      p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
      q.delete();
    end else begin
      bit ev;
      bit ph;
      int a, k, b;
      exp_t e;
      ev = p2 ^ p3;
      p3 = p2; p2 = p1; p1 = key_tgl;
      edge_n++;
      a = int'(area); k = int'(key_index);
      if (clear) begin
        m_map = '0; m_go = 1'b0;
      end else if (ev && !m_go) begin
        b = 16 * (4 * (a / 4) + k / 4) + 4 * (a % 4) + k % 4;
        if (BOMB[b]) begin
          m_go = 1'b1; m_gstart = edge_n;
        end else begin
          m_map[b] = ~m_map[b];
        end
      end
      ph = !m_go || (((edge_n - m_gstart) / FC) % 2 == 0);
      e.r = 8'hFF;
      e.r[7 - m_row] = 1'b0;
      for (int j = 0; j < 16; j++)
        e.c[j] = ph && (m_map[16 * m_row + j] || (m_go && BOMB[16 * m_row + j]));
      e.go  = m_go;
      e.cnt = 8'($countones(m_map));
      q.push_back(e);
      m_row = (m_row + 1) % 8;
    end
  end

  // Monitor: every clock presents a scan word, so pop and compare once per cycle.
  always @(negedge div_clk_10k) begin
    if (reset && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("dot_r", 32'(dot_r), 32'(e.r));
      chk("dot_c", 32'(dot_c), 32'(e.c));
      chk("gameover", 32'(gameover), 32'(e.go));
      chk("mark_count", 32'(mark_count), 32'(e.cnt));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge div_clk_10k);
    #2;
  endtask

  task automatic press(input logic [2:0] a, input logic [3:0] i);
    step(1);
    area = a; key_index = i;
    step(1);
    key_tgl = ~key_tgl;
    step(6);
  endtask

  // Toggle the key, then pulse clear d cycles later; d=2 lands clear on the event edge.
  task automatic press_clear(input logic [2:0] a, input logic [3:0] i, input int d);
    step(1);
    area = a; key_index = i;
    step(1);
    key_tgl = ~key_tgl;
    if (d > 0) step(d);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(6);
  endtask

  initial begin
    reset = 1'b0; key_tgl = 1'b0; key_index = 4'd0; area = 3'd0; clear = 1'b0;
    repeat (3) @(posedge div_clk_10k);
    #1;
    chk("rst_dot_r", 32'(dot_r), 32'hFF);
    chk("rst_dot_c", 32'(dot_c), 32'h0);
    chk("rst_count", 32'(mark_count), 32'h0);
    chk("rst_gameover", 32'(gameover), 32'h0);
    step(1);
    reset = 1'b1;
    step(16);

    press(3'd5, 4'd6);
    step(8);
    chk("bit86_count", 32'(mark_count), 32'd1);
    press(3'd5, 4'd6);
    press(3'd1, 4'd3);
    press(3'd7, 4'd15);
    press(3'd2, 4'd9);
    step(8);
    chk("three_marks", 32'(mark_count), 32'd3);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] a;
      logic [3:0] i;
      a = 3'($urandom_range(7));
      i = 4'($urandom_range(15));
      if (a == 3'd0 && i == 4'd0) i = 4'd1;
      if ($urandom_range(7) == 0) press_clear(a, i, int'($urandom_range(4)));
      else press(a, i);
      step(int'($urandom_range(3)));
    end

    press(3'd6, 4'd2);
    press_clear(3'd4, 4'd5, 2);
    chk("clear_count", 32'(mark_count), 32'd0);
    press(3'd4, 4'd5);
    press(3'd3, 4'd12);

    press(3'd0, 4'd0);
    chk("bomb_gameover", 32'(gameover), 32'd1);
    chk("bomb_count", 32'(mark_count), 32'd2);
    step(3000);
    press(3'd3, 4'd3);
    step(8000);
    chk("ignored_count", 32'(mark_count), 32'd2);

    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(4);
    press(3'd2, 4'd2);
    press(3'd7, 4'd0);
    press(3'd1, 4'd1);
    step(1);
    key_tgl = ~key_tgl;
    step(1);
    reset = 1'b0;
    #1;
    chk("mid_dot_r", 32'(dot_r), 32'hFF);
    chk("mid_dot_c", 32'(dot_c), 32'h0);
    chk("mid_count", 32'(mark_count), 32'h0);
    key_tgl = 1'b0;
    step(3);
    reset = 1'b1;
    step(20);
    press(3'd5, 4'd6);
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
